fifo_rd_stream: RTL and testbench
=================================

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Purpose: single-clock read-side consumer for the dual-clock FIFO read port (registered memory read, 1-cycle latency). Converts pop/empty into a valid/ready stream with a 2-entry prefetch buffer. Sustains 1 word/cycle.

Interface
REQ-001 Parameter DATA_WIDTH, default 8, word width; SHALL match the FIFO DATA_WIDTH.
REQ-002 Parameter CNT_WIDTH, default 16, width of the delivered-word counter.
REQ-003 r_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 r_rstn  input  1  reset, asynchronous assert, active-low.
REQ-005 fifo_empty  input  1  FIFO empty flag, synchronous to r_clk.
REQ-006 fifo_r_en  output  1  pop request to the FIFO read port.
REQ-007 fifo_r_data  input  DATA_WIDTH  FIFO read data, valid on the cycle after an accepted pop.
REQ-008 drain_en  input  1  1 = issue pops; 0 = no new pops, buffered words still delivered.
REQ-009 m_valid  output  1  output word available.
REQ-010 m_ready  input  1  downstream accepts the word.
REQ-011 m_data  output  DATA_WIDTH  output word.
REQ-012 rd_count  output  CNT_WIDTH  count of words transferred on the output (m_valid && m_ready).

Function
REQ-013 A pop is accepted when fifo_r_en=1 at a rising edge; fifo_r_en SHALL never be 1 while fifo_empty=1.
REQ-014 inflight register: set to 1 on the edge where a pop is accepted, otherwise cleared; fifo_r_data SHALL be written into the buffer tail on the edge where inflight=1.
REQ-015 occ (buffer occupancy) SHALL take values 0/1/2 only, with states EMPTY, ONE, TWO.
REQ-016 out_xfer = m_valid && m_ready; fifo_r_en = drain_en && !fifo_empty && (occ + inflight - out_xfer < 2). fifo_r_en is combinational from m_ready.
REQ-017 occ transitions per edge: +1 if inflight && !out_xfer; -1 if out_xfer && !inflight; unchanged otherwise.
REQ-018 Words SHALL leave in FIFO pop order; m_data SHALL be the head entry, with no reordering, loss or duplication.
REQ-019 m_valid SHALL equal (occ != 0); landing data is not bypassed combinationally (min latency: pop edge -> m_valid 2 edges later is wrong; the required latency is 1 edge after the landing edge, i.e. m_valid high on the cycle after inflight=1).
REQ-020 While m_valid=1 and m_ready=0, m_valid and m_data SHALL hold stable.
REQ-021 Simultaneous landing and output transfer in TWO: head pops, landing word enters the tail, occ stays 2; REQ-016 guarantees no overflow.
REQ-022 With FIFO non-empty, drain_en=1, and m_ready held 1, throughput SHALL be 1 word/cycle after a 2-cycle fill.
REQ-023 drain_en falling: no new pop from that cycle; a pop already in flight SHALL still land and be delivered.
REQ-024 rd_count SHALL increment by 1 on each out_xfer and wrap modulo 2^CNT_WIDTH with no saturation.

Reset
REQ-025 While r_rstn=0: occ=0, inflight=0, m_valid=0, m_data=0, rd_count=0, buffer entries=0, fifo_r_en=0 (gated by reset).
REQ-026 Reset mid-operation SHALL discard buffered and in-flight words without a deferred landing after release. First pop is possible on the first edge after deassertion.

Verification
REQ-027 Reset with fifo_empty=0 -> fifo_r_en=0 and m_valid=0 throughout reset; m_valid=1 two edges after release.
REQ-028 FIFO holds 0x11..0x18, m_ready=1 -> m_data 0x11..0x18 on 8 consecutive cycles, rd_count=8, fifo_r_en never high with fifo_empty=1.
REQ-029 Buffer filled, m_ready=0 for 5 cycles -> occ=2, fifo_r_en=0, m_data stable; m_ready=1 -> no word lost or duplicated.
REQ-030 Random m_ready and random fifo_empty over 10k words -> output sequence equals pop sequence, occ<=2 always.
REQ-031 drain_en dropped the same cycle a pop is accepted -> the in-flight word is delivered, and no further pops occur.
REQ-032 CNT_WIDTH=4, 17 transfers -> rd_count=1; reset asserted with occ=2 -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/fifo_rd_stream.sv
// Read-side consumer for the FIFO read port: turns pop/empty into a valid/ready
// stream through a two-entry prefetch buffer, sustaining one word per cycle.
module fifo_rd_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  r_clk,
    input  logic                  r_rstn,
    input  logic                  fifo_empty,
    output logic                  fifo_r_en,
    input  logic [DATA_WIDTH-1:0] fifo_r_data,
    input  logic                  drain_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [CNT_WIDTH-1:0]  rd_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_e;

    occ_e                  occ_q, occ_d;
    logic                  inflight_q, inflight_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    logic [CNT_WIDTH-1:0]  rdCount_q, rdCount_d;
    logic                  outXfer;
    logic [1:0]            held;

    assign m_valid  = (occ_q != EMPTY);
    assign m_data   = head_q;
    assign rd_count = rdCount_q;
    assign outXfer  = m_valid && m_ready;

    // Words already committed to the buffer (stored plus landing); a new pop is
    // only issued if it will still fit once this cycle's output transfer leaves.
    assign held      = occ_q + {1'b0, inflight_q};
    assign fifo_r_en = r_rstn && drain_en && !fifo_empty &&
                       (held < (2'd2 + {1'b0, outXfer}));

    always_comb begin
        occ_d      = occ_q;
        inflight_d = fifo_r_en;
        head_d     = head_q;
        tail_d     = tail_q;
        rdCount_d  = rdCount_q;
        if (outXfer) begin
            rdCount_d = rdCount_q + CNT_WIDTH'(1);
        end
        case ({inflight_q, outXfer})
            2'b10: begin
                if (occ_q == EMPTY) begin
                    head_d = fifo_r_data;
                    occ_d  = ONE;
                end else begin
                    tail_d = fifo_r_data;
                    occ_d  = TWO;
                end
            end
            2'b01: begin
                head_d = tail_q;
                occ_d  = (occ_q == TWO) ? ONE : EMPTY;
            end
            // Landing while the head leaves: occupancy is unchanged, the
            // landing word takes whichever slot becomes the tail.
            2'b11: begin
                if (occ_q == TWO) begin
                    head_d = tail_q;
                    tail_d = fifo_r_data;
                end else begin
                    head_d = fifo_r_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge r_clk or negedge r_rstn) begin
        if (!r_rstn) begin
            occ_q      <= EMPTY;
            inflight_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            rdCount_q  <= '0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            rdCount_q  <= rdCount_d;
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Self-checking bench for fifo_rd_stream: a queue-based model of the FIFO and of
// the words owed downstream, compared against the DUT every cycle.
module tb_fifo_rd_stream;

    localparam int DW = 8;
    localparam int CW = 4;

    logic          r_clk       = 1'b0;
    logic          r_rstn      = 1'b0;
    logic          fifo_empty  = 1'b1;
    logic          drain_en    = 1'b0;
    logic          m_ready     = 1'b0;
    logic [DW-1:0] fifo_r_data = '0;
    logic          fifo_r_en;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic [CW-1:0] rd_count;

    fifo_rd_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .r_clk      (r_clk),
        .r_rstn     (r_rstn),
        .fifo_empty (fifo_empty),
        .fifo_r_en  (fifo_r_en),
        .fifo_r_data(fifo_r_data),
        .drain_en   (drain_en),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .rd_count   (rd_count)
    );

    always #5 r_clk = ~r_clk;

    typedef struct {
        logic [DW-1:0] word;
        int            vis;
    } owed_t;

    owed_t         owedQ[$];
    logic [DW-1:0] fifoQ[$];
    logic [DW-1:0] outSeq[$];
    logic [DW-1:0] refQ[$];
    int            cyc = 0;
    int            xfers = 0;
    int            checks = 0;
    int            passes = 0;
    bit            popDec = 0;
    bit            xferDec = 0;
    bit            holdReset = 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic clearModel();
        owedQ.delete();
        xfers   = 0;
        popDec  = 0;
        xferDec = 0;
    endtask

    // One clock cycle: retire the previous edge into the model, drive new
    // inputs, then compare the settled outputs well before the next edge.
    task automatic applyStimulus(input bit rdy, input bit drn, input bit fEmpty);
        logic [DW-1:0] w;
        bit            expValid;
        bit            expXfer;
        bit            expRen;
        @(posedge r_clk);
        #1;
        cyc++;
        if (xferDec) begin
            if (owedQ.size() > 0) begin
                outSeq.push_back(owedQ[0].word);
                void'(owedQ.pop_front());
            end
            xfers++;
        end
        if (popDec) begin
            w = (fifoQ.size() > 0) ? fifoQ.pop_front() : DW'($urandom);
            fifo_r_data = w;
            owedQ.push_back('{w, cyc + 1});
        end else begin
            fifo_r_data = DW'($urandom);
        end
        r_rstn     = !holdReset;
        m_ready    = rdy;
        drain_en   = drn;
        fifo_empty = fEmpty || (fifoQ.size() == 0);
        #2;
        if (!r_rstn) begin
            checkOutput("rst_m_valid", 32'(m_valid), 32'd0);
            checkOutput("rst_fifo_r_en", 32'(fifo_r_en), 32'd0);
            checkOutput("rst_m_data", 32'(m_data), 32'd0);
            checkOutput("rst_rd_count", 32'(rd_count), 32'd0);
            clearModel();
        end else begin
            expValid = (owedQ.size() > 0) && (owedQ[0].vis <= cyc);
            expXfer  = expValid && m_ready;
            expRen   = drain_en && !fifo_empty && ((owedQ.size() - int'(expXfer)) < 2);
            checkOutput("m_valid", 32'(m_valid), 32'(expValid));
            if (expValid) checkOutput("m_data", 32'(m_data), 32'(owedQ[0].word));
            checkOutput("fifo_r_en", 32'(fifo_r_en), 32'(expRen));
            checkOutput("rd_count", 32'(rd_count), 32'(xfers % (1 << CW)));
            popDec  = fifo_r_en;
            xferDec = m_valid && m_ready;
        end
    endtask

    task automatic assertResetAsync();
        r_rstn    = 1'b0;
        holdReset = 1;
        #1;
        checkOutput("async_m_valid", 32'(m_valid), 32'd0);
        checkOutput("async_m_data", 32'(m_data), 32'd0);
        checkOutput("async_rd_count", 32'(rd_count), 32'd0);
        checkOutput("async_fifo_r_en", 32'(fifo_r_en), 32'd0);
        clearModel();
    endtask

    initial begin
        logic [DW-1:0] expSeq[8];
        int relCyc;
        int firstValid;
        int firstX;
        int lastX;
        int errs;

        expSeq = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
        for (int i = 0; i < 8; i++) fifoQ.push_back(expSeq[i]);

        // Reset held with a non-empty FIFO, then the back-to-back drain.
        repeat (3) applyStimulus(1, 1, 0);
        holdReset  = 0;
        firstValid = -1;
        firstX     = -1;
        lastX      = -1;
        applyStimulus(1, 1, 0);
        relCyc = cyc;
        for (int i = 0; i < 40 && outSeq.size() < 8; i++) begin
            applyStimulus(1, 1, 0);
            if (m_valid && firstValid < 0) firstValid = cyc;
            if (xferDec) begin
                if (firstX < 0) firstX = cyc;
                lastX = cyc;
            end
        end
        checkOutput("valid_latency", 32'(firstValid - relCyc), 32'd2);
        checkOutput("burst_len", 32'(outSeq.size()), 32'd8);
        checkOutput("burst_span", 32'(lastX - firstX), 32'd7);
        checkOutput("burst_count", 32'(rd_count), 32'd8);
        for (int i = 0; i < 8 && i < outSeq.size(); i++)
            checkOutput("burst_word", 32'(outSeq[i]), 32'(expSeq[i]));

        // Downstream stall with a full buffer.
        outSeq.delete();
        for (int i = 0; i < 6; i++) fifoQ.push_back(DW'(8'h21 + i));
        repeat (8) applyStimulus(0, 1, 0);
        checkOutput("stall_valid", 32'(m_valid), 32'd1);
        checkOutput("stall_r_en", 32'(fifo_r_en), 32'd0);
        checkOutput("stall_data", 32'(m_data), 32'h21);
        checkOutput("stall_fifo_left", 32'(fifoQ.size()), 32'd4);
        for (int i = 0; i < 30 && outSeq.size() < 6; i++) applyStimulus(1, 1, 0);
        checkOutput("stall_len", 32'(outSeq.size()), 32'd6);
        for (int i = 0; i < 6 && i < outSeq.size(); i++)
            checkOutput("stall_word", 32'(outSeq[i]), 32'(8'h21 + i));
        checkOutput("stall_count", 32'(rd_count), 32'd14);

        // drain_en drops right after a pop is accepted.
        outSeq.delete();
        fifoQ.push_back(8'h31);
        fifoQ.push_back(8'h32);
        fifoQ.push_back(8'h33);
        repeat (2) applyStimulus(1, 0, 0);
        applyStimulus(1, 1, 0);
        checkOutput("drain_pop", 32'(fifo_r_en), 32'd1);
        repeat (6) applyStimulus(1, 0, 0);
        checkOutput("drain_len", 32'(outSeq.size()), 32'd1);
        if (outSeq.size() > 0) checkOutput("drain_word", 32'(outSeq[0]), 32'h31);
        checkOutput("drain_fifo_left", 32'(fifoQ.size()), 32'd2);
        checkOutput("drain_count", 32'(rd_count), 32'd15);

        // Fill to two entries, reset asynchronously, then count wrap.
        for (int i = 0; i < 4; i++) fifoQ.push_back(DW'(8'h41 + i));
        repeat (4) applyStimulus(0, 1, 0);
        checkOutput("pre_rst_valid", 32'(m_valid), 32'd1);
        assertResetAsync();
        fifoQ.delete();
        outSeq.delete();
        for (int i = 0; i < 17; i++) fifoQ.push_back(DW'(8'h50 + i));
        repeat (2) applyStimulus(1, 1, 0);
        holdReset = 0;
        for (int i = 0; i < 40 && outSeq.size() < 17; i++) applyStimulus(1, 1, 0);
        checkOutput("wrap_len", 32'(outSeq.size()), 32'd17);
        if (outSeq.size() > 0) checkOutput("wrap_first", 32'(outSeq[0]), 32'h50);
        checkOutput("wrap_count", 32'(rd_count), 32'd1);

        // Random backpressure and FIFO emptiness over a long stream.
        outSeq.delete();
        refQ.delete();
        for (int i = 0; i < 10000; i++) begin
            fifoQ.push_back(DW'($urandom));
            refQ.push_back(fifoQ[fifoQ.size() - 1]);
        end
        for (int i = 0; i < 60000 && outSeq.size() < 10000; i++)
            applyStimulus($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 95,
                          $urandom_range(0, 99) < 20);
        checkOutput("rand_len", 32'(outSeq.size()), 32'd10000);
        errs = 0;
        for (int i = 0; i < outSeq.size() && i < refQ.size(); i++)
            if (outSeq[i] !== refQ[i]) errs++;
        checkOutput("rand_order_errors", 32'(errs), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
